// File: rtl/sub_32b_seq_pkg.sv
// sub_32b_seq_pkg: FSM states and sizing helpers for the chunked subtractor.
package sub_32b_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int nchunk(int w, int c);
    return w / c;
  endfunction
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sub_32b_seq_if.sv
// sub_32b_seq_if: operand/result valid-ready bundle of the chunked subtractor.
interface sub_32b_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow_out;
  logic             ovf;
  logic             zero;
  modport master (output in_valid, a, b, borrow_in, out_ready,
                  input  in_ready, out_valid, d, borrow_out, ovf, zero);
  modport slave  (input  in_valid, a, b, borrow_in, out_ready,
                  output in_ready, out_valid, d, borrow_out, ovf, zero);
endinterface

// File: rtl/fa_1b.sv
// fa_1b: one-bit full adder cell.
module fa_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/sub_32b_seq_chunk.sv
// sub_32b_seq_chunk: combinational a + ~b + c_i over one chunk, exposing the carry into the msb.
module sub_32b_seq_chunk #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a_s_i,
  input  logic [CHUNK-1:0] b_s_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] d_s_o,
  output logic             c_o,
  output logic             c_msb_o
);
  logic [CHUNK:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa_1b u_fa (.a_i(a_s_i[i]), .b_i(~b_s_i[i]), .c_i(c[i]), .s_o(d_s_o[i]), .c_o(c[i+1]));
  end
  assign c_o     = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];
endmodule

// File: rtl/sub_32b_seq.sv
// sub_32b_seq: multi-cycle d = a - b - borrow_in, CHUNK bits per cycle, one op in flight.
module sub_32b_seq
  import sub_32b_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic          clk,
  input logic          rst_n,
  sub_32b_seq_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_w(NCHUNK);
  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("sub_32b_seq: WIDTH must be a multiple of CHUNK");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q, d_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q, borrow_q, ovf_q, zero_q;
  logic [CHUNK-1:0] d_s;
  logic             c_out, c_msb, accept, last;
  assign accept = bus.in_valid && state_q == IDLE;
  assign last   = idx_q == IW'(NCHUNK - 1);
  sub_32b_seq_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_s_i   (a_q[idx_q*CHUNK +: CHUNK]),
    .b_s_i   (b_q[idx_q*CHUNK +: CHUNK]),
    .c_i     (carry_q),
    .d_s_o   (d_s),
    .c_o     (c_out),
    .c_msb_o (c_msb)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (bus.in_valid ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
                                (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
  end
  always_comb begin
    d_d = d_q;
    d_d[idx_q*CHUNK +: CHUNK] = d_s;
  end
  // Borrow crosses chunk boundaries only through carry_q (held inverted).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= ~bus.borrow_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      d_q     <= d_d;
      carry_q <= c_out;
      idx_q   <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        borrow_q <= ~c_out;
        ovf_q    <= c_msb ^ c_out;
        zero_q   <= ~|d_d;
      end
    end
  assign bus.d          = d_q;
  assign bus.borrow_out = borrow_q;
  assign bus.ovf        = ovf_q;
  assign bus.zero       = zero_q;
endmodule
